// File: rtl/char_addr_gen_pkg.sv
// Shared constants for the character address generator.
package char_addr_gen_pkg;

  // Text grid after reset
  localparam int DEF_ROWS_C = 128;
  localparam int DEF_COLS_C = 160;

  // Glyph cell is 8x8 pixels unless overridden
  localparam int CELL_W_LOG2_C = 3;
  localparam int CELL_H_LOG2_C = 3;

  // vsync_in is active-high unless overridden
  localparam int VSYNC_POL_C = 1;

endpackage

// File: rtl/char_mult_add.sv
// Registered a*b + c used to form row*columns + column.
module char_mult_add #(
  parameter int DIM_W  = 8,
  parameter int ADDR_W = 16
) (
  input  logic              CLK_108MHz,
  input  logic              reset,
  input  logic [DIM_W-1:0]  a,
  input  logic [DIM_W-1:0]  b,
  input  logic [DIM_W-1:0]  c,
  output logic [ADDR_W-1:0] y
);

  // Wide enough for the exact product plus addend, and never narrower than the result.
  localparam int FULL_W = 2 * DIM_W + 1;
  localparam int SUM_W  = (FULL_W > ADDR_W) ? FULL_W : ADDR_W;

  logic [SUM_W-1:0] a_ext;
  logic [SUM_W-1:0] b_ext;
  logic [SUM_W-1:0] c_ext;

  assign a_ext = SUM_W'(a);
  assign b_ext = SUM_W'(b);
  assign c_ext = SUM_W'(c);

  // Multiply-add at full width, keep the low ADDR_W bits.
  always_ff @(posedge CLK_108MHz) begin
    if (reset) begin
      y <= '0;
    end else begin
      y <= ADDR_W'(a_ext * b_ext + c_ext);
    end
  end

endmodule

// File: rtl/char_addr_gen.sv
// Pixel counters -> character-RAM address, with scroll, blanking and blinking cursor.
module char_addr_gen
  import char_addr_gen_pkg::*;
#(
  parameter int CTR_W       = 11,
  parameter int CELL_W_LOG2 = CELL_W_LOG2_C,
  parameter int CELL_H_LOG2 = CELL_H_LOG2_C,
  parameter int DIM_W       = 8,
  parameter int ADDR_W      = 16,
  parameter int VSYNC_POL   = VSYNC_POL_C,
  parameter int BLINK_LOG2  = 5,
  parameter int DEF_ROWS    = DEF_ROWS_C,
  parameter int DEF_COLS    = DEF_COLS_C
) (
  input  logic                   CLK_108MHz,
  input  logic                   reset,
  input  logic [CTR_W-1:0]       hctr_in,
  input  logic [CTR_W-1:0]       vctr_in,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   de_in,
  input  logic [DIM_W-1:0]       max_rows,
  input  logic [DIM_W-1:0]       max_columns,
  input  logic [DIM_W-1:0]       scroll_row,
  input  logic [DIM_W-1:0]       cursor_row,
  input  logic [DIM_W-1:0]       cursor_col,
  input  logic                   cursor_en,
  input  logic                   blink_en,
  output logic [CELL_W_LOG2-1:0] hctr_out,
  output logic [CELL_H_LOG2-1:0] vctr_out,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic                   de_out,
  output logic [ADDR_W-1:0]      address_out,
  output logic                   blank_out,
  output logic                   cursor_out
);

  localparam logic VS_ACT = (VSYNC_POL != 0);

  // Scrolled row folded back into [0, rows); valid because row < rows and scroll < rows.
  function automatic logic [DIM_W-1:0] wrap_row(input logic [DIM_W-1:0] row,
                                               input logic [DIM_W-1:0] scroll,
                                               input logic [DIM_W-1:0] rows);
    logic [DIM_W:0] sum;
    sum = {1'b0, row} + {1'b0, scroll};
    if (sum >= {1'b0, rows}) begin
      sum = sum - {1'b0, rows};
    end
    return sum[DIM_W-1:0];
  endfunction

  // A scroll offset outside the grid falls back to the top row.
  function automatic logic [DIM_W-1:0] clamp_scroll(input logic [DIM_W-1:0] scroll,
                                                   input logic [DIM_W-1:0] rows);
    return (scroll >= rows) ? '0 : scroll;
  endfunction

  logic                  vsync_q;
  logic                  vsync_start;
  logic [DIM_W-1:0]      rows_sh;
  logic [DIM_W-1:0]      cols_sh;
  logic [DIM_W-1:0]      scroll_sh;
  logic [DIM_W-1:0]      cur_row_sh;
  logic [DIM_W-1:0]      cur_col_sh;
  logic                  cur_en_sh;
  logic                  blink_en_sh;
  logic [BLINK_LOG2:0]   frame_cnt;

  assign vsync_start = (vsync_in == VS_ACT) && (vsync_q != VS_ACT);

  // Frame-synchronous shadow registers and blink frame counter.
  always_ff @(posedge CLK_108MHz) begin
    if (reset) begin
      vsync_q     <= ~VS_ACT;
      rows_sh     <= DIM_W'(DEF_ROWS);
      cols_sh     <= DIM_W'(DEF_COLS);
      scroll_sh   <= '0;
      cur_row_sh  <= '0;
      cur_col_sh  <= '0;
      cur_en_sh   <= 1'b0;
      blink_en_sh <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      vsync_q <= vsync_in;
      if (vsync_start) begin
        rows_sh     <= max_rows;
        cols_sh     <= max_columns;
        scroll_sh   <= clamp_scroll(scroll_row, max_rows);
        cur_row_sh  <= cursor_row;
        cur_col_sh  <= cursor_col;
        cur_en_sh   <= cursor_en;
        blink_en_sh <= blink_en;
        frame_cnt   <= frame_cnt + {{BLINK_LOG2{1'b0}}, 1'b1};
      end
    end
  end

  // ---- stage 0: cell coordinates from the raw counters ----
  logic [DIM_W-1:0] col_p0;
  logic [DIM_W-1:0] row_p0;
  logic [DIM_W-1:0] wrow_p0;
  logic             blank_p0;
  logic             cur_p0;

  assign col_p0   = DIM_W'(hctr_in[CTR_W-1:CELL_W_LOG2]);
  assign row_p0   = DIM_W'(vctr_in[CTR_W-1:CELL_H_LOG2]);
  assign wrow_p0  = wrap_row(row_p0, scroll_sh, rows_sh);
  assign blank_p0 = (row_p0 >= rows_sh) || (col_p0 >= cols_sh);
  assign cur_p0   = cur_en_sh && (row_p0 == cur_row_sh) && (col_p0 == cur_col_sh) &&
                    (!blink_en_sh || frame_cnt[BLINK_LOG2]);

  // ---- stage 1: registered cell state; blanked cells feed zero operands ----
  logic [CELL_W_LOG2-1:0] hpix_p1;
  logic [CELL_H_LOG2-1:0] vpix_p1;
  logic                   hsync_p1;
  logic                   vsync_p1;
  logic                   vld_p1;
  logic                   blank_p1;
  logic                   cur_p1;
  logic [DIM_W-1:0]       mul_a_p1;
  logic [DIM_W-1:0]       mul_b_p1;
  logic [DIM_W-1:0]       mul_c_p1;

  // First pipeline stage: cell lookup results and pass-through signals.
  always_ff @(posedge CLK_108MHz) begin
    if (reset) begin
      hpix_p1  <= '0;
      vpix_p1  <= '0;
      hsync_p1 <= 1'b0;
      vsync_p1 <= 1'b0;
      vld_p1   <= 1'b0;
      blank_p1 <= 1'b0;
      cur_p1   <= 1'b0;
      mul_a_p1 <= '0;
      mul_b_p1 <= '0;
      mul_c_p1 <= '0;
    end else begin
      hpix_p1  <= hctr_in[CELL_W_LOG2-1:0];
      vpix_p1  <= vctr_in[CELL_H_LOG2-1:0];
      hsync_p1 <= hsync_in;
      vsync_p1 <= vsync_in;
      vld_p1   <= de_in;
      blank_p1 <= blank_p0;
      cur_p1   <= cur_p0;
      mul_a_p1 <= blank_p0 ? '0 : wrow_p0;
      mul_b_p1 <= blank_p0 ? '0 : cols_sh;
      mul_c_p1 <= blank_p0 ? '0 : col_p0;
    end
  end

  // ---- stage 2: address multiply-add and final output registers ----
  char_mult_add #(
    .DIM_W  (DIM_W),
    .ADDR_W (ADDR_W)
  ) u_mult_add (
    .CLK_108MHz (CLK_108MHz),
    .reset      (reset),
    .a          (mul_a_p1),
    .b          (mul_b_p1),
    .c          (mul_c_p1),
    .y          (address_out)
  );

  // Second pipeline stage for everything except the address.
  always_ff @(posedge CLK_108MHz) begin
    if (reset) begin
      hctr_out   <= '0;
      vctr_out   <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      de_out     <= 1'b0;
      blank_out  <= 1'b0;
      cursor_out <= 1'b0;
    end else begin
      hctr_out   <= hpix_p1;
      vctr_out   <= vpix_p1;
      hsync_out  <= hsync_p1;
      vsync_out  <= vsync_p1;
      de_out     <= vld_p1;
      blank_out  <= blank_p1;
      cursor_out <= cur_p1 && !blank_p1;
    end
  end

endmodule

// File: tb/tb_char_addr_gen.sv
// Self-checking bench for char_addr_gen against a frame-level reference model.
module tb_char_addr_gen;

  localparam int BLINK_LOG2 = 1;

  typedef struct packed {
    logic [2:0]  hpix;
    logic [2:0]  vpix;
    logic        hs;
    logic        vs;
    logic        de;
    logic [15:0] addr;
    logic        blank;
    logic        cursor;
  } cell_t;

  logic        CLK_108MHz = 1'b0;
  logic        reset;
  logic [10:0] hctr_in, vctr_in;
  logic        hsync_in, vsync_in, de_in;
  logic [7:0]  max_rows, max_columns, scroll_row, cursor_row, cursor_col;
  logic        cursor_en, blink_en;
  logic [2:0]  hctr_out, vctr_out;
  logic        hsync_out, vsync_out, de_out;
  logic [15:0] address_out;
  logic        blank_out, cursor_out;

  int ncmp = 0;
  int nfail = 0;

  // Reference model state: what the screen geometry is for the current frame.
  int m_rows, m_cols, m_scroll, m_crow, m_ccol, m_cen, m_blink, m_frame, m_prev_vs;
  cell_t q[$];

  char_addr_gen #(.BLINK_LOG2(BLINK_LOG2)) dut (
    .CLK_108MHz (CLK_108MHz), .reset (reset),
    .hctr_in (hctr_in), .vctr_in (vctr_in),
    .hsync_in (hsync_in), .vsync_in (vsync_in), .de_in (de_in),
    .max_rows (max_rows), .max_columns (max_columns), .scroll_row (scroll_row),
    .cursor_row (cursor_row), .cursor_col (cursor_col),
    .cursor_en (cursor_en), .blink_en (blink_en),
    .hctr_out (hctr_out), .vctr_out (vctr_out),
    .hsync_out (hsync_out), .vsync_out (vsync_out), .de_out (de_out),
    .address_out (address_out), .blank_out (blank_out), .cursor_out (cursor_out)
  );

  always #5 CLK_108MHz = ~CLK_108MHz;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic cell_t model_cell();
    cell_t c;
    int col, row, disp;
    c = '0;
    col = int'(hctr_in[10:3]);
    row = int'(vctr_in[10:3]);
    c.hpix = hctr_in[2:0];
    c.vpix = vctr_in[2:0];
    c.hs = hsync_in;
    c.vs = vsync_in;
    c.de = de_in;
    c.blank = (row >= m_rows) || (col >= m_cols);
    if (!c.blank) begin
      disp = (row + m_scroll) % m_rows;
      c.addr = 16'((disp * m_cols + col) % 65536);
      c.cursor = (m_cen != 0) && (row == m_crow) && (col == m_ccol) &&
                 ((m_blink == 0) || (((m_frame >> BLINK_LOG2) & 1) == 1));
    end
    return c;
  endfunction

  task automatic model_reset();
    m_rows = 128; m_cols = 160; m_scroll = 0; m_crow = 0; m_ccol = 0;
    m_cen = 0; m_blink = 0; m_frame = 0; m_prev_vs = 0;
  endtask

  task automatic model_frame_edge();
    if (vsync_in && (m_prev_vs == 0)) begin
      m_rows   = int'(max_rows);
      m_cols   = int'(max_columns);
      m_scroll = (int'(scroll_row) >= int'(max_rows)) ? 0 : int'(scroll_row);
      m_crow   = int'(cursor_row);
      m_ccol   = int'(cursor_col);
      m_cen    = int'(cursor_en);
      m_blink  = int'(blink_en);
      m_frame  = (m_frame + 1) % (1 << (BLINK_LOG2 + 1));
    end
    m_prev_vs = int'(vsync_in);
  endtask

  // One clock: predict, advance, sample outputs, return the prediction due now.
  task automatic tick(output cell_t obs, output cell_t expd);
    cell_t e;
    e = model_cell();
    if (reset) begin
      q.delete();
      q.push_back('0);
      q.push_back('0);
      model_reset();
    end else begin
      q.push_back(e);
      model_frame_edge();
    end
    @(posedge CLK_108MHz);
    #1;
    obs = {hctr_out, vctr_out, hsync_out, vsync_out, de_out, address_out, blank_out, cursor_out};
    expd = q.pop_front();
  endtask

  task automatic set_cell(input int row, input int col, input int px, input int py);
    hctr_in = 11'(col * 8 + px);
    vctr_in = 11'(row * 8 + py);
  endtask

  task automatic vsync_pulse();
    cell_t o, e;
    de_in = 1'b0;
    vsync_in = 1'b1; tick(o, e); tick(o, e);
    vsync_in = 1'b0; tick(o, e);
    de_in = 1'b1;
  endtask

  task automatic test_reset();
    cell_t o, e;
    reset = 1'b1;
    de_in = 1'b1; hsync_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(o, e);
      ncmp++;
      if (o !== cell_t'('0)) begin
        nfail++; $display("FAIL reset_outputs got=%h exp=0", o);
      end
    end
    reset = 1'b0;
    hsync_in = 1'b0;
    hctr_in = 11'd83; vctr_in = 11'd20;
    tick(o, e); tick(o, e);
    ncmp++;
    if (o.addr !== 16'd330 || o.hpix !== 3'd3 || o.vpix !== 3'd4 || o.blank !== 1'b0) begin
      nfail++; $display("FAIL default_geom got=%0d/%0d/%0d/%0d exp=330/3/4/0", o.addr, o.hpix, o.vpix, o.blank);
    end
    ncmp++;
    if (o !== e) begin nfail++; $display("FAIL default_model got=%h exp=%h", o, e); end
  endtask

  task automatic test_scroll_wrap();
    cell_t o, e;
    max_rows = 8'd30; max_columns = 8'd80; scroll_row = 8'd25;
    vsync_pulse();
    set_cell(7, 0, 1, 2);
    tick(o, e); tick(o, e);
    ncmp++;
    if (o.addr !== 16'd160 || o.blank !== 1'b0) begin
      nfail++; $display("FAIL scroll_wrap_r7 got=%0d exp=160", o.addr);
    end
    set_cell(4, 0, 0, 0);
    tick(o, e); tick(o, e);
    ncmp++;
    if (o.addr !== 16'd2320) begin nfail++; $display("FAIL scroll_r4 got=%0d exp=2320", o.addr); end
    ncmp++;
    if (o !== e) begin nfail++; $display("FAIL scroll_model got=%h exp=%h", o, e); end
  endtask

  task automatic test_clamp_blank();
    cell_t o, e;
    max_rows = 8'd30; max_columns = 8'd80; scroll_row = 8'd40;
    vsync_pulse();
    set_cell(3, 5, 0, 0);
    tick(o, e); tick(o, e);
    ncmp++;
    if (o.addr !== 16'd245) begin nfail++; $display("FAIL clamp_addr got=%0d exp=245", o.addr); end
    set_cell(3, 80, 2, 2);
    tick(o, e); tick(o, e);
    ncmp++;
    if (o.blank !== 1'b1 || o.addr !== 16'd0) begin
      nfail++; $display("FAIL blank_col got=%0d/%0d exp=1/0", o.blank, o.addr);
    end
    set_cell(30, 0, 0, 0);
    tick(o, e); tick(o, e);
    ncmp++;
    if (o.blank !== 1'b1 || o.addr !== 16'd0) begin
      nfail++; $display("FAIL blank_row got=%0d/%0d exp=1/0", o.blank, o.addr);
    end
    max_rows = 8'd0; cursor_row = 8'd0; cursor_col = 8'd0; cursor_en = 1'b1; blink_en = 1'b0;
    vsync_pulse();
    for (int i = 0; i < 10; i++) begin
      if (i == 0) set_cell(0, 0, 0, 0);
      else set_cell($urandom_range(0, 255), $urandom_range(0, 255), 0, 0);
      tick(o, e);
      ncmp++;
      if (i > 0 && (o.blank !== 1'b1 || o.addr !== 16'd0 || o.cursor !== 1'b0)) begin
        nfail++; $display("FAIL rows0_blank got=%0d/%0d/%0d exp=1/0/0", o.blank, o.addr, o.cursor);
      end else if (o !== e) begin
        nfail++; $display("FAIL rows0_model got=%h exp=%h", o, e);
      end
    end
    cursor_en = 1'b0;
  endtask

  task automatic test_shadowing();
    cell_t o, e;
    max_rows = 8'd30; max_columns = 8'd80; scroll_row = 8'd0;
    vsync_pulse();
    max_columns = 8'd100;
    set_cell(3, 5, 0, 0);
    tick(o, e); tick(o, e);
    ncmp++;
    if (o.addr !== 16'd245) begin nfail++; $display("FAIL shadow_hold got=%0d exp=245", o.addr); end
    vsync_in = 1'b1;
    tick(o, e);
    tick(o, e);
    ncmp++;
    if (o.addr !== 16'd245) begin nfail++; $display("FAIL shadow_start got=%0d exp=245", o.addr); end
    tick(o, e);
    ncmp++;
    if (o.addr !== 16'd305) begin nfail++; $display("FAIL shadow_new got=%0d exp=305", o.addr); end
    ncmp++;
    if (o !== e) begin nfail++; $display("FAIL shadow_model got=%h exp=%h", o, e); end
    vsync_in = 1'b0;
    tick(o, e);
  endtask

  task automatic test_cursor_blink();
    cell_t o, e;
    logic seen[6];
    max_rows = 8'd30; max_columns = 8'd80; scroll_row = 8'd3;
    cursor_row = 8'd2; cursor_col = 8'd5; cursor_en = 1'b1; blink_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      vsync_pulse();
      set_cell(2, 5, 4, 4);
      tick(o, e); tick(o, e);
      seen[f] = o.cursor;
      ncmp++;
      if (o !== e) begin nfail++; $display("FAIL blink_model f=%0d got=%h exp=%h", f, o, e); end
    end
    for (int f = 0; f < 4; f++) begin
      ncmp++;
      if (seen[f] === seen[f+2]) begin
        nfail++; $display("FAIL blink_alternate f=%0d got=%0d exp=%0d", f, seen[f+2], !seen[f]);
      end
    end
    blink_en = 1'b0;
    for (int f = 0; f < 3; f++) begin
      vsync_pulse();
      set_cell(2, 5, 0, 7);
      tick(o, e); tick(o, e);
      ncmp++;
      if (o.cursor !== 1'b1) begin nfail++; $display("FAIL cursor_steady got=%0d exp=1", o.cursor); end
      set_cell(2, 6, 0, 0);
      tick(o, e); tick(o, e);
      ncmp++;
      if (o.cursor !== 1'b0) begin nfail++; $display("FAIL cursor_other got=%0d exp=0", o.cursor); end
    end
    cursor_en = 1'b0;
  endtask

  task automatic test_random();
    cell_t o, e;
    for (int f = 0; f < 12; f++) begin
      max_rows    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(20, 60));
      max_columns = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(40, 160));
      scroll_row  = 8'($urandom_range(0, 80));
      cursor_row  = 8'($urandom_range(0, 3));
      cursor_col  = 8'($urandom_range(0, 3));
      cursor_en   = 1'($urandom_range(0, 1));
      blink_en    = 1'($urandom_range(0, 1));
      vsync_pulse();
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 1) == 0) set_cell($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 7), $urandom_range(0, 7));
        else begin hctr_in = 11'($urandom_range(0, 2047)); vctr_in = 11'($urandom_range(0, 2047)); end
        hsync_in = 1'($urandom_range(0, 1));
        de_in    = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 19) == 0) begin
          max_rows = 8'($urandom); max_columns = 8'($urandom); scroll_row = 8'($urandom);
        end
        if ($urandom_range(0, 49) == 0) vsync_in = ~vsync_in;
        tick(o, e);
        ncmp++;
        if (o !== e) begin nfail++; $display("FAIL random f=%0d i=%0d got=%h exp=%h", f, i, o, e); end
      end
      vsync_in = 1'b0;
      tick(o, e);
    end
    hsync_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    cell_t o, e;
    de_in = 1'b1; hsync_in = 1'b1;
    set_cell(5, 7, 1, 1);
    tick(o, e); tick(o, e);
    reset = 1'b1;
    tick(o, e);
    ncmp++;
    if (o !== cell_t'('0)) begin nfail++; $display("FAIL midreset_zero got=%h exp=0", o); end
    reset = 1'b0;
    set_cell(2, 10, 3, 4);
    tick(o, e);
    ncmp++;
    if (o !== cell_t'('0)) begin nfail++; $display("FAIL midreset_flush got=%h exp=0", o); end
    tick(o, e);
    ncmp++;
    if (o.de !== 1'b1 || o.addr !== 16'd330) begin
      nfail++; $display("FAIL midreset_resume got=%0d/%0d exp=1/330", o.de, o.addr);
    end
    ncmp++;
    if (o !== e) begin nfail++; $display("FAIL midreset_model got=%h exp=%h", o, e); end
  endtask

  initial begin
    reset = 1'b1;
    hctr_in = '0; vctr_in = '0; hsync_in = 1'b0; vsync_in = 1'b0; de_in = 1'b0;
    max_rows = 8'd128; max_columns = 8'd160; scroll_row = '0;
    cursor_row = '0; cursor_col = '0; cursor_en = 1'b0; blink_en = 1'b0;
    model_reset();
    test_reset();
    test_scroll_wrap();
    test_clamp_blank();
    test_shadowing();
    test_cursor_blink();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/char_addr_gen.md
Name: char_addr_gen

Overview:
- Parametrised successor to the text-mode dot-address stage; sits between the dot-clock timing generator and the character RAM / font ROM lookup.
- Converts pixel counters into a character-RAM address: address = wrapped_row * columns + col.
- Adds the following, all delay-matched to the address:
  - configurable glyph cell size;
  - vertical scroll with row wrap-around;
  - out-of-grid blanking;
  - a blinking cursor flag.
- Geometry/scroll/cursor inputs are shadowed once per frame so mid-frame writes never tear.

Parameters:
- CTR_W, 11, width of hctr_in / vctr_in.
- CELL_W_LOG2, 3, log2 glyph width in pixels.
- CELL_H_LOG2, 3, log2 glyph height in pixels.
- DIM_W, 8, width of row/column/scroll/cursor quantities.
- ADDR_W, 16, character-RAM address width.
- VSYNC_POL, 1, active level of vsync_in (1 = active-high).
- BLINK_LOG2, 5, cursor toggles every 2^BLINK_LOG2 frames.
- DEF_ROWS, 128, max_rows shadow value after reset.
- DEF_COLS, 160, max_columns shadow value after reset.

Ports:
- CLK_108MHz  in  1  global pixel clock.
- reset  in  1  synchronous, active-high reset.
- hctr_in  in  CTR_W  horizontal pixel counter.
- vctr_in  in  CTR_W  vertical pixel counter.
- hsync_in  in  1  horizontal sync.
- vsync_in  in  1  vertical sync.
- de_in  in  1  data enable.
- max_rows  in  DIM_W  text rows; shadowed.
- max_columns  in  DIM_W  text columns; shadowed.
- scroll_row  in  DIM_W  first displayed memory row; shadowed.
- cursor_row  in  DIM_W  cursor row, screen coordinates; shadowed.
- cursor_col  in  DIM_W  cursor column; shadowed.
- cursor_en  in  1  cursor enable; shadowed.
- blink_en  in  1  1 = cursor blinks, 0 = steady; shadowed.
- hctr_out  out  CELL_W_LOG2  pixel x inside cell.
- vctr_out  out  CELL_H_LOG2  pixel y inside cell.
- hsync_out  out  1  delayed hsync.
- vsync_out  out  1  delayed vsync.
- de_out  out  1  delayed data enable.
- address_out  out  ADDR_W  character-RAM address.
- blank_out  out  1  cell lies outside the rows x columns grid.
- cursor_out  out  1  cursor visible on this cell.

Behaviour:
- Single clock domain. Reset is synchronous: sampled only on the CLK_108MHz rising edge.
- All outputs reset to 0. Shadows reset to DEF_ROWS / DEF_COLS, scroll 0, cursor 0, cursor_en 0, blink_en 0. Frame counter resets to 0.
- Latency: exactly 2 cycles from inputs to every output.
- Pass-through outputs (hctr_out, vctr_out, hsync_out, vsync_out, de_out) use two flop stages each:
  - hctr_out = hctr_in[CELL_W_LOG2-1:0];
  - vctr_out = vctr_in[CELL_H_LOG2-1:0].
- Vsync start: cycle where vsync_in goes inactive -> active per VSYNC_POL, detected against a registered copy of vsync_in. On that cycle:
  - all shadow registers load from their inputs;
  - the frame counter (BLINK_LOG2+1 bits) increments, wrapping freely.
- Shadow loads take effect from the next cycle. Addresses computed while vsync is active may use old or new values; the data enable is low there, so this is accepted.
- Scroll clamping at load: if scroll_row >= max_rows, the shadow scroll loads as 0.
- Stage 1 (registered):
  - col = hctr_in[CTR_W-1:CELL_W_LOG2], truncated to DIM_W.
  - row = vctr_in[CTR_W-1:CELL_H_LOG2], truncated to DIM_W.
  - sum = row + scroll, computed in DIM_W+1 bits.
  - wrapped_row = sum - rows if sum >= rows, else sum (single conditional subtract).
  - blank = (row >= rows) or (col >= cols).
  - cursor_hit = cursor_en & row==cursor_row & col==cursor_col. Compared in screen coordinates, i.e. unscrolled.
- Stage 2 (inside sub-module):
  - address_out = wrapped_row * cols + col, computed full width, then truncated to ADDR_W;
  - blank_out registered from stage 1 blank;
  - cursor_out = cursor_hit & ~blank & (~blink_en | frame_cnt[BLINK_LOG2]).
- While blank: address_out is forced to 0 (avoids out-of-range RAM reads).
- rows == 0 or cols == 0: every cell is blank; address_out is 0 and cursor_out is 0.
- Reset asserted mid-frame: all pipeline contents are discarded. Outputs are 0 on the cycle after the reset edge. Normal output resumes 2 cycles after reset deasserts.

Decomposition:
- Shared package constants:
  - default geometry (DEF_ROWS, DEF_COLS);
  - CELL_*_LOG2 defaults;
  - VSYNC_POL.
- One sub-module, char_mult_add: registered (a*b + c) with synchronous reset, parametrised by DIM_W and ADDR_W. It replaces the old fixed 8-bit multiply-add.

Test Plan:
- Reset, defaults, scroll 0: hctr_in=83, vctr_in=20 -> 2 cycles later address_out=2*160+10=330, hctr_out=3, vctr_out=4, blank_out=0.
- Scroll wrap: rows=30, cols=80, scroll_row=25 loaded at vsync start; screen row 7 col 0 -> address_out=(32-30)*80=160. Screen row 4 -> 29*80=2320.
- Scroll clamp and blanking:
  - scroll_row=40, rows=30 -> treated as 0.
  - col 80 -> blank_out=1, address_out=0.
  - screen row 30 -> blank_out=1.
  - rows=0 -> blank on every cell.
- Shadowing: change cols 80->100 mid-frame -> addresses keep using 80 until the vsync start, then use 100 from the following cycle.
- Cursor blink: cursor at (2,5), cursor_en=1, blink_en=1, BLINK_LOG2=1 -> cursor_out on that cell alternates every 2 frames. With blink_en=0 it stays high; on any other cell it stays 0.
- Sync reset mid-pipeline: assert reset for 1 cycle while de_in=1 -> all outputs 0 next cycle; valid outputs resume 2 cycles after release.
